// File: rtl/shift_reg_sequencer_if.sv
// Command, response, serial and register-control signals between the sequencer and its environment.
// The slave modport is the sequencer side; the master modport drives commands and owns the register.
interface shift_reg_sequencer_if #(
  parameter int W = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_op;
  logic [W-1:0] cmd_data;

  logic         bit_en;
  logic         sin;
  logic         sout;
  logic         sout_valid;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;

  logic         reg_clr;
  logic         reg_ld;
  logic         reg_shl;
  logic         reg_shin;
  logic [W-1:0] reg_d;
  logic [W-1:0] reg_q;

  modport master (
    output cmd_valid, cmd_op, cmd_data, bit_en, sin, rsp_ready, reg_q,
    input  cmd_ready, sout, sout_valid, rsp_valid, rsp_data,
           reg_clr, reg_ld, reg_shl, reg_shin, reg_d
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, bit_en, sin, rsp_ready, reg_q,
    output cmd_ready, sout, sout_valid, rsp_valid, rsp_data,
           reg_clr, reg_ld, reg_shl, reg_shin, reg_d
  );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Drives an external load/clear/shift-left register as a W-bit serializer (TX) or deserializer (RX).
// Outputs decode state and inputs combinationally; one command in flight, RX result held until rsp_ready.
module shift_reg_sequencer #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  shift_reg_sequencer_if.slave bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    RX   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic         cmd_ready;
  logic         sout;
  logic         sout_valid;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         reg_clr;
  logic         reg_ld;
  logic         reg_shl;
  logic         reg_shin;
  logic [W-1:0] reg_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d = bus.cmd_op ? RX : TX;
          cnt_d   = '0;
        end
      end
      TX, RX: begin
        if (bus.bit_en) begin
          if (cnt_q == CNT_LAST) begin
            state_d = (state_q == TX) ? IDLE : RESP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every output is forced low while reset is held, independent of the registered state.
  always_comb begin
    cmd_ready  = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    reg_clr    = 1'b0;
    reg_ld     = 1'b0;
    reg_shl    = 1'b0;
    reg_shin   = 1'b0;
    reg_d      = '0;
    if (rstn) begin
      case (state_q)
        IDLE: begin
          cmd_ready = 1'b1;
          reg_d     = bus.cmd_data;
          reg_ld    = bus.cmd_valid && !bus.cmd_op;
          reg_clr   = bus.cmd_valid &&  bus.cmd_op;
        end
        TX: begin
          reg_shl    = bus.bit_en;
          sout       = bus.reg_q[W-1];
          sout_valid = bus.bit_en;
        end
        RX: begin
          reg_shl  = bus.bit_en;
          reg_shin = bus.sin;
        end
        RESP: begin
          rsp_valid = 1'b1;
          rsp_data  = bus.reg_q;
        end
        default: begin
          cmd_ready = 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.sout       = sout;
  assign bus.sout_valid = sout_valid;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_data   = rsp_data;
  assign bus.reg_clr    = reg_clr;
  assign bus.reg_ld     = reg_ld;
  assign bus.reg_shl    = reg_shl;
  assign bus.reg_shin   = reg_shin;
  assign bus.reg_d      = reg_d;
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer with W=4: directed scenarios, a queue-based reference model
// checked every cycle, and a short burst of random traffic.
module tb_shift_reg_sequencer;
  localparam int W = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  shift_reg_sequencer_if #(.W(W)) bus ();
  shift_reg_sequencer #(.W(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  // External register with its own behaviour: clr > ld > shl.
  logic [W-1:0] regq = '0;
  always @(posedge clk) begin
    if (bus.reg_clr)      regq <= '0;
    else if (bus.reg_ld)  regq <= bus.reg_d;
    else if (bus.reg_shl) regq <= {regq[W-2:0], bus.reg_shin};
  end
  assign bus.reg_q = regq;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: transfer phase plus the bits still to send / bits collected so far.
  typedef enum {M_IDLE, M_TX, M_RX, M_RESP} mphase_t;
  mphase_t      ph = M_IDLE;
  bit           tx_q[$];
  logic [W-1:0] rx_val = '0;
  int           rx_n = 0;
  int           tx_accepts = 0;

  int           sv_pulses = 0;
  logic [31:0]  sv_word = 0;
  int           ld_cnt = 0;
  int           clr_cnt = 0;
  int           shl_noen = 0;
  int           rsp_cnt = 0;
  logic [W-1:0] rsp_last = '0;

  task automatic clr_stats();
    sv_pulses = 0; sv_word = 0; ld_cnt = 0; clr_cnt = 0;
    shl_noen = 0; rsp_cnt = 0; rsp_last = '0;
  endtask

  always @(negedge clk) begin
    logic         e_ready, e_sout, e_sv, e_rv, e_clr, e_ld, e_shl, e_shin;
    logic [W-1:0] e_d;
    e_ready = 0; e_sout = 0; e_sv = 0; e_rv = 0;
    e_clr = 0; e_ld = 0; e_shl = 0; e_shin = 0; e_d = '0;
    if (rstn) begin
      case (ph)
        M_IDLE: begin
          e_ready = 1;
          e_d     = bus.cmd_data;
          e_ld    = bus.cmd_valid && !bus.cmd_op;
          e_clr   = bus.cmd_valid &&  bus.cmd_op;
        end
        M_TX: begin
          e_sout = tx_q[0];
          e_sv   = bus.bit_en;
          e_shl  = bus.bit_en;
        end
        M_RX: begin
          e_shl  = bus.bit_en;
          e_shin = bus.sin;
        end
        default: e_rv = 1;
      endcase
    end
    chk("cmd_ready", bus.cmd_ready, e_ready);
    chk("sout", bus.sout, e_sout);
    chk("sout_valid", bus.sout_valid, e_sv);
    chk("rsp_valid", bus.rsp_valid, e_rv);
    if (e_rv) chk("rsp_data", bus.rsp_data, rx_val);
    chk("reg_clr", bus.reg_clr, e_clr);
    chk("reg_ld", bus.reg_ld, e_ld);
    chk("reg_shl", bus.reg_shl, e_shl);
    chk("reg_shin", bus.reg_shin, e_shin);
    chk("reg_d", bus.reg_d, e_d);
    chk("strobe_onehot0", $onehot0({bus.reg_clr, bus.reg_ld, bus.reg_shl}), 1);

    if (bus.sout_valid) begin
      sv_pulses++;
      sv_word = (sv_word << 1) | bus.sout;
    end
    if (bus.reg_ld)  ld_cnt++;
    if (bus.reg_clr) clr_cnt++;
    if (bus.reg_shl && !bus.bit_en) shl_noen++;
    if (bus.rsp_valid) begin
      rsp_cnt++;
      rsp_last = bus.rsp_data;
    end

    if (!rstn) begin
      ph = M_IDLE;
      tx_q.delete();
    end else begin
      case (ph)
        M_IDLE: if (bus.cmd_valid) begin
          if (bus.cmd_op) begin
            ph = M_RX; rx_val = '0; rx_n = 0;
          end else begin
            ph = M_TX; tx_q.delete(); tx_accepts++;
            for (int i = W - 1; i >= 0; i--) tx_q.push_back(bus.cmd_data[i]);
          end
        end
        M_TX: if (bus.bit_en) begin
          void'(tx_q.pop_front());
          if (tx_q.size() == 0) ph = M_IDLE;
        end
        M_RX: if (bus.bit_en) begin
          rx_val = {rx_val[W-2:0], bus.sin};
          rx_n++;
          if (rx_n == W) ph = M_RESP;
        end
        default: if (bus.rsp_ready) ph = M_IDLE;
      endcase
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic op, input logic [W-1:0] d);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    while (!bus.cmd_ready && n < 100) begin
      cycle();
      n++;
    end
    chk("cmd_accept", bus.cmd_ready, 1);
    cycle();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic shift_bits(input logic [W-1:0] d, input int stride);
    for (int i = W - 1; i >= 0; i--) begin
      repeat (stride - 1) begin
        bus.bit_en = 1'b0;
        cycle();
      end
      bus.bit_en = 1'b1;
      bus.sin    = d[i];
      cycle();
    end
    bus.bit_en = 1'b0;
    bus.sin    = 1'b0;
  endtask

  task automatic xfer(input logic op, input logic [W-1:0] d, input int stride);
    send_cmd(op, d);
    shift_bits(d, stride);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_data = '0;
    bus.bit_en = 0; bus.sin = 0; bus.rsp_ready = 0;
    rstn = 1'b0;
    repeat (3) cycle();
    chk("reset_cmd_ready", bus.cmd_ready, 0);
    chk("reset_reg_d", bus.reg_d, 0);
    rstn = 1'b1;
    #1;
    chk("post_reset_cmd_ready", bus.cmd_ready, 1);
    cycle();

    // TX 1010 with continuous strobe: MSB first, ready again W+1 cycles after accept.
    clr_stats();
    bus.rsp_ready = 1'b1;
    xfer(1'b0, 4'b1010, 1);
    chk("t1_ready_at_W+1", bus.cmd_ready, 1);
    chk("t1_pulses", sv_pulses, 4);
    chk("t1_bits", sv_word, 32'hA);
    chk("t1_ld_once", ld_cnt, 1);

    // RX 1,1,0,1 with consumer ready.
    clr_stats();
    xfer(1'b1, 4'b1101, 1);
    chk("t2_rsp_valid", bus.rsp_valid, 1);
    cycle();
    chk("t2_rsp_cycles", rsp_cnt, 1);
    chk("t2_rsp_data", rsp_last, 4'b1101);
    chk("t2_clr_once", clr_cnt, 1);
    chk("t2_ready", bus.cmd_ready, 1);

    // TX 0110 with a strobe every third cycle.
    clr_stats();
    xfer(1'b0, 4'b0110, 3);
    chk("t3_pulses", sv_pulses, 4);
    chk("t3_bits", sv_word, 32'h6);
    chk("t3_no_shl_without_en", shl_noen, 0);

    // RX 1001 with response stalled for 5 cycles; commands in that window are ignored.
    clr_stats();
    bus.rsp_ready = 1'b0;
    xfer(1'b1, 4'b1001, 1);
    for (int j = 0; j < 5; j++) begin
      chk("t4_hold_valid", bus.rsp_valid, 1);
      chk("t4_hold_data", bus.rsp_data, 4'b1001);
      chk("t4_busy", bus.cmd_ready, 0);
      bus.cmd_valid = (j % 2 == 1);
      cycle();
    end
    bus.rsp_ready = 1'b1;
    chk("t4_last_valid", bus.rsp_valid, 1);
    cycle();
    chk("t4_released", bus.rsp_valid, 0);
    chk("t4_rsp_cycles", rsp_cnt, 6);
    chk("t4_no_ld", ld_cnt, 0);
    chk("t4_clr_once", clr_cnt, 1);

    // TX 1111 aborted by reset after two bits, then a fresh RX.
    clr_stats();
    send_cmd(1'b0, 4'b1111);
    bus.bit_en = 1'b1;
    cycle();
    cycle();
    rstn = 1'b0;
    cycle();
    chk("t5_rst_ready", bus.cmd_ready, 0);
    chk("t5_rst_sv", bus.sout_valid, 0);
    chk("t5_rst_shl", bus.reg_shl, 0);
    chk("t5_rst_sout", bus.sout, 0);
    rstn = 1'b1;
    bus.bit_en = 1'b0;
    #1;
    chk("t5_idle_after_rst", bus.cmd_ready, 1);
    chk("t5_partial_pulses", sv_pulses, 2);
    xfer(1'b1, 4'b0001, 1);
    chk("t5_rx_valid", bus.rsp_valid, 1);
    chk("t5_rx_data", bus.rsp_data, 4'b0001);
    cycle();

    // Random traffic, then drain so every accepted TX completes.
    clr_stats();
    tx_accepts = 0;
    repeat (400) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_op    = 1'($urandom_range(0, 1));
      bus.cmd_data  = W'($urandom);
      bus.bit_en    = 1'($urandom_range(0, 1));
      bus.sin       = 1'($urandom_range(0, 1));
      bus.rsp_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    bus.cmd_valid = 1'b0;
    bus.bit_en    = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (W + 4) cycle();
    chk("rand_sv_per_tx", sv_pulses, W * tx_accepts);
    chk("rand_drained", bus.cmd_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/shift_reg_sequencer.md
Name: shift_reg_sequencer

Overview:
- FSM controller that drives the control pins of a W-bit load/clear/shift-left register (clr, ld, shl, shin; q fed back) to act as a serializer (TX) or deserializer (RX).
- Accepts one command at a time over a valid/ready handshake.
- Paces shifting with a bit-strobe so that serial rate is below clk rate.
- Returns RX words over a valid/ready response handshake.

Parameters:
- W, 8, register width and number of bits per transfer (W >= 2).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rstn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller idle and able to accept a command.
- cmd_op  in  1  0 = TX (serialize cmd_data), 1 = RX (deserialize).
- cmd_data  in  W  parallel word for TX; ignored for RX.
- bit_en  in  1  bit strobe; one shift per cycle with bit_en=1.
- sin  in  1  serial input, sampled on RX shift cycles.
- sout  out  1  serial output, reg_q[W-1] in TX state, else 0.
- sout_valid  out  1  high in TX state when bit_en=1; marks the bit being sent.
- rsp_valid  out  1  RX word available.
- rsp_ready  in  1  consumer accepts RX word.
- rsp_data  out  W  RX word, equals reg_q while rsp_valid.
- reg_clr  out  1  to register clr.
- reg_ld  out  1  to register ld.
- reg_shl  out  1  to register shl.
- reg_shin  out  1  to register shin.
- reg_d  out  W  to register d.
- reg_q  in  W  register q feedback.

Behaviour:
- Reset and clocking:
  - Reset is synchronous and active-low on rstn; there is one clock, clk.
  - rstn=0 at a posedge puts the state in IDLE and the bit counter at 0.
  - While rstn=0, every output is 0, including cmd_ready, all reg_* strobes and rsp_valid. These outputs are gated combinationally by rstn.
  - The controller does not clear the register; the register has its own reset.
- States: IDLE, TX, RX, RESP. Outputs are combinational decodes of state and inputs; there are no output pipeline stages.
- IDLE:
  - cmd_ready=1.
  - reg_d=cmd_data at all times while in IDLE; reg_d=0 in all other states.
  - On cmd_valid with cmd_op=0, reg_ld=1 in the same cycle; next state TX, cnt=0.
  - On cmd_valid with cmd_op=1, reg_clr=1 in the same cycle; next state RX, cnt=0.
- TX:
  - reg_shin=0.
  - reg_shl=bit_en.
  - sout=reg_q[W-1].
  - sout_valid=bit_en.
  - On a cycle with bit_en=1, cnt increments. When cnt==W-1 and bit_en=1, next state is IDLE.
  - Bits leave MSB first. Exactly W sout_valid pulses occur per TX command.
- RX:
  - reg_shl=bit_en.
  - reg_shin=sin.
  - The counter works as in TX. After the W-th strobe the next state is RESP.
  - The first sampled bit ends up in reg_q[W-1].
- RESP:
  - rsp_valid=1 and rsp_data=reg_q; both are held stable until rsp_ready=1.
  - On the rsp_valid && rsp_ready cycle, next state is IDLE.
  - No register strobes are asserted.
- Busy: cmd_ready=0 in TX, RX and RESP. cmd_valid is ignored there and has no side effects.
- Strobe exclusivity: at most one of reg_clr, reg_ld, reg_shl is high in any cycle.
- Latency:
  - Command acceptance to first sout_valid is at least 1 cycle.
  - A TX with continuous bit_en returns cmd_ready=1 exactly W+1 cycles after the accept edge cycle.
  - An RX with continuous bit_en raises rsp_valid W+1 cycles after accept.
- Counter: cnt width is $clog2(W). It never exceeds W-1 and resets to 0 on every accept.
- bit_en stalls: with bit_en=0 the state, cnt and register hold. bit_en is ignored in IDLE and RESP.
- Reset mid-operation: the next cycle is IDLE with all strobes 0. Any partial transfer is discarded and no rsp is generated.
- Back-to-back commands: a new command can be accepted in the first IDLE cycle after TX completes or after the RESP handshake.

Test Plan:
- W=4, bit_en=1 constant, TX cmd_data=4'b1010 -> reg_ld pulses 1 cycle; sout on successive sout_valid cycles = 1,0,1,0; cmd_ready=1 again 5 cycles after accept.
- W=4, RX with sin sequence 1,1,0,1 and rsp_ready=1 -> reg_clr pulses once; rsp_valid for 1 cycle with rsp_data=4'b1101.
- TX 4'b0110 with bit_en high only every 3rd cycle -> exactly 4 sout_valid pulses carrying 0,1,1,0; reg_shl never high while bit_en=0.
- RX 4'b1001 with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data=4'b1001 stable for all 6 cycles; cmd_valid pulsed during this window is ignored (cmd_ready=0, no strobes).
- TX 4'b1111, drive rstn=0 after 2 bits -> next cycle all outputs 0; after rstn=1, cmd_ready=1 and a new RX 0,0,0,1 returns 4'b0001.
- Strobe-exclusivity assertion over random cmd/bit_en/rsp_ready traffic -> never more than one of reg_clr/reg_ld/reg_shl high; TX sout_valid count is always W per command.
